// File: rtl/vend_payout_ctrl_if.sv
// Handshake and data bundle between the vend controller and the coin-accept FSM, motor and hopper.
interface vend_payout_ctrl_if;
  logic       vend_req;
  logic [2:0] change_amt;
  logic       item_drop;
  logic       coin_ack;
  logic       load;
  logic [3:0] load_dimes;
  logic [3:0] load_nickels;
  logic       fault_clr;
  logic       motor;
  logic       eject_dime;
  logic       eject_nickel;
  logic       busy;
  logic       done;
  logic       fault;
  logic [3:0] dime_cnt;
  logic [3:0] nickel_cnt;
  logic       low_change;

  modport master (
    output vend_req, change_amt, item_drop, coin_ack, load, load_dimes, load_nickels, fault_clr,
    input  motor, eject_dime, eject_nickel, busy, done, fault, dime_cnt, nickel_cnt, low_change
  );

  modport slave (
    input  vend_req, change_amt, item_drop, coin_ack, load, load_dimes, load_nickels, fault_clr,
    output motor, eject_dime, eject_nickel, busy, done, fault, dime_cnt, nickel_cnt, low_change
  );
endinterface

// File: rtl/vend_payout_ctrl.sv
// Vend sequencer: runs the item motor, then pays change greedily (dimes first) one acknowledged coin at a time.
// Motor, eject and done are registered; busy, fault and low_change decode the current state/counts.
module vend_payout_ctrl #(
  parameter int MOTOR_TO = 16,
  parameter int ACK_TO   = 8
) (
  input logic              clk,
  input logic              rst,
  vend_payout_ctrl_if.slave bus
);

  localparam int TMAX = (MOTOR_TO > ACK_TO) ? MOTOR_TO : ACK_TO;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VEND, S_PAY_SEL, S_PAY_WAIT, S_DONE, S_FAULT
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     rem_q, rem_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [3:0]     dime_q, dime_d;
  logic [3:0]     nick_q, nick_d;
  logic           motor_q, motor_d;
  logic           ej_dime_q, ej_dime_d;
  logic           ej_nick_q, ej_nick_d;
  logic           done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      timer_q   <= '0;
      dime_q    <= '0;
      nick_q    <= '0;
      motor_q   <= 1'b0;
      ej_dime_q <= 1'b0;
      ej_nick_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      timer_q   <= timer_d;
      dime_q    <= dime_d;
      nick_q    <= nick_d;
      motor_q   <= motor_d;
      ej_dime_q <= ej_dime_d;
      ej_nick_q <= ej_nick_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    timer_d   = timer_q;
    dime_d    = dime_q;
    nick_d    = nick_q;
    motor_d   = motor_q;
    ej_dime_d = 1'b0;
    ej_nick_d = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A load and a vend in the same cycle are both honoured.
        if (bus.load) begin
          dime_d = bus.load_dimes;
          nick_d = bus.load_nickels;
        end
        if (bus.vend_req) begin
          rem_d   = bus.change_amt;
          timer_d = '0;
          motor_d = 1'b1;
          state_d = S_VEND;
        end
      end
      S_VEND: begin
        if (bus.item_drop) begin
          motor_d = 1'b0;
          timer_d = '0;
          state_d = S_PAY_SEL;
        end else if (timer_q >= TW'(MOTOR_TO)) begin
          motor_d = 1'b0;
          timer_d = '0;
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_PAY_SEL: begin
        timer_d = '0;
        if (rem_q == 3'd0) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (rem_q >= 3'd2 && dime_q != 4'd0) begin
          ej_dime_d = 1'b1;
          rem_d     = rem_q - 3'd2;
          dime_d    = dime_q - 4'd1;
          state_d   = S_PAY_WAIT;
        end else if (nick_q != 4'd0) begin
          ej_nick_d = 1'b1;
          rem_d     = rem_q - 3'd1;
          nick_d    = nick_q - 4'd1;
          state_d   = S_PAY_WAIT;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_PAY_WAIT: begin
        if (bus.coin_ack) begin
          timer_d = '0;
          state_d = S_PAY_SEL;
        end else if (timer_q >= TW'(ACK_TO)) begin
          timer_d = '0;
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        motor_d = 1'b0;
        if (bus.load) begin
          dime_d = bus.load_dimes;
          nick_d = bus.load_nickels;
        end
        if (bus.fault_clr) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.motor        = motor_q;
  assign bus.eject_dime   = ej_dime_q;
  assign bus.eject_nickel = ej_nick_q;
  assign bus.done         = done_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.fault        = (state_q == S_FAULT);
  assign bus.dime_cnt     = dime_q;
  assign bus.nickel_cnt   = nick_q;
  assign bus.low_change   = (nick_q < 4'd2) || (dime_q == 4'd0);

endmodule

// File: tb/tb_vend_payout_ctrl.sv
// Directed scenarios followed by randomized vends checked against a greedy-change arithmetic model.
module tb_vend_payout_ctrl;
  localparam int MOTOR_TO = 16;
  localparam int ACK_TO   = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  vend_payout_ctrl_if bus();

  vend_payout_ctrl #(.MOTOR_TO(MOTOR_TO), .ACK_TO(ACK_TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_load(input int d, input int n);
    bus.load = 1'b1;
    bus.load_dimes = 4'(d);
    bus.load_nickels = 4'(n);
    step();
    bus.load = 1'b0;
  endtask

  task automatic clr_fault();
    bus.fault_clr = 1'b1;
    step();
    bus.fault_clr = 1'b0;
    chk("clr_busy", bus.busy, 0);
    chk("clr_fault", bus.fault, 0);
  endtask

  // Drives one vend from IDLE, acks every coin after a random delay, and tallies ejects until done/fault.
  task automatic do_vend(input int chg, input int drop_dly, input bit ld, input int ld_d, input int ld_n,
                         input bit stray, output int nd, output int nn,
                         output bit got_done, output bit got_fault);
    bit nick_seen;
    int k;
    nd = 0; nn = 0; got_done = 1'b0; got_fault = 1'b0; nick_seen = 1'b0;
    bus.vend_req = 1'b1;
    bus.change_amt = 3'(chg);
    bus.load = ld;
    bus.load_dimes = 4'(ld_d);
    bus.load_nickels = 4'(ld_n);
    step();
    bus.vend_req = 1'b0;
    bus.load = 1'b0;
    chk("vend_motor", bus.motor, 1);
    chk("vend_busy", bus.busy, 1);
    for (int i = 0; i < drop_dly; i++) begin
      if (stray && i == 0) begin
        bus.vend_req = 1'b1;
        bus.change_amt = 3'd7;
        bus.coin_ack = 1'b1;
        bus.load = 1'b1;
        bus.load_dimes = 4'd15;
        bus.load_nickels = 4'd15;
      end
      step();
      bus.vend_req = 1'b0;
      bus.coin_ack = 1'b0;
      bus.load = 1'b0;
    end
    bus.item_drop = 1'b1;
    step();
    bus.item_drop = 1'b0;
    chk("drop_motor", bus.motor, 0);
    for (int cyc = 0; cyc < 100 && !got_done && !got_fault; cyc++) begin
      if (bus.done) got_done = 1'b1;
      else if (bus.fault) got_fault = 1'b1;
      else if (bus.eject_dime || bus.eject_nickel) begin
        chk("one_eject", bus.eject_dime & bus.eject_nickel, 0);
        if (bus.eject_dime) begin
          chk("dime_after_nickel", nick_seen, 0);
          nd++;
        end
        if (bus.eject_nickel) begin
          nick_seen = 1'b1;
          nn++;
        end
        k = $urandom_range(0, 3);
        if (k == 0) bus.coin_ack = 1'b1;
        step();
        bus.coin_ack = 1'b0;
        chk("eject_width", {bus.eject_dime, bus.eject_nickel}, 0);
        if (k != 0) begin
          repeat (k - 1) step();
          bus.coin_ack = 1'b1;
          step();
          bus.coin_ack = 1'b0;
        end
      end else step();
    end
    chk("payout_end", got_done | got_fault, 1);
    if (got_done) begin
      step();
      chk("done_width", bus.done, 0);
      chk("done_idle", bus.busy, 0);
    end
  endtask

  initial begin
    int nd, nn, md, mn, chg, ed, en, r, d, n;
    bit gd, gf, ld, efault;

    bus.vend_req = 0; bus.change_amt = 0; bus.item_drop = 0; bus.coin_ack = 0;
    bus.load = 0; bus.load_dimes = 0; bus.load_nickels = 0; bus.fault_clr = 0;

    #1 rst = 1'b1;
    #1;
    chk("rst_motor", bus.motor, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_ej", {bus.eject_dime, bus.eject_nickel}, 0);
    chk("rst_cnt", {bus.dime_cnt, bus.nickel_cnt}, 0);
    chk("rst_low", bus.low_change, 1);
    @(negedge clk);
    rst = 1'b0;

    // Normal vend with change 3: one dime then one nickel.
    do_load(4, 4);
    do_vend(3, 2, 0, 0, 0, 0, nd, nn, gd, gf);
    chk("v3_dimes", nd, 1);
    chk("v3_nickels", nn, 1);
    chk("v3_done", gd, 1);
    chk("v3_cnt", {bus.dime_cnt, bus.nickel_cnt}, {4'd3, 4'd3});

    // Zero change: no coins, counts unchanged.
    do_vend(0, 1, 0, 0, 0, 1, nd, nn, gd, gf);
    chk("v0_ejects", nd + nn, 0);
    chk("v0_done", gd, 1);
    chk("v0_cnt", {bus.dime_cnt, bus.nickel_cnt}, {4'd3, 4'd3});

    // Motor timeout after MOTOR_TO+1 cycles without item_drop.
    bus.vend_req = 1'b1; bus.change_amt = 3'd1;
    step();
    bus.vend_req = 1'b0;
    repeat (MOTOR_TO) step();
    chk("mto_early_fault", bus.fault, 0);
    chk("mto_early_motor", bus.motor, 1);
    step();
    chk("mto_fault", bus.fault, 1);
    chk("mto_motor", bus.motor, 0);
    bus.vend_req = 1'b1; bus.change_amt = 3'd5;
    step();
    bus.vend_req = 1'b0;
    chk("mto_vend_ignored", bus.fault, 1);
    chk("mto_cnt", {bus.dime_cnt, bus.nickel_cnt}, {4'd3, 4'd3});
    clr_fault();

    // Short change: no dimes, one nickel, change 2.
    do_load(0, 1);
    do_vend(2, 1, 0, 0, 0, 0, nd, nn, gd, gf);
    chk("short_nickels", nn, 1);
    chk("short_dimes", nd, 0);
    chk("short_fault", gf, 1);
    chk("short_ncnt", bus.nickel_cnt, 0);
    chk("short_low", bus.low_change, 1);
    clr_fault();

    // Ack timeout after ACK_TO+1 cycles; stray vend_req while busy.
    do_load(4, 4);
    bus.vend_req = 1'b1; bus.change_amt = 3'd2;
    step();
    bus.vend_req = 1'b0;
    bus.item_drop = 1'b1;
    step();
    bus.item_drop = 1'b0;
    step();
    chk("ato_eject", bus.eject_dime, 1);
    bus.vend_req = 1'b1; bus.change_amt = 3'd7;
    step();
    bus.vend_req = 1'b0;
    repeat (ACK_TO - 1) step();
    chk("ato_early_fault", bus.fault, 0);
    step();
    chk("ato_fault", bus.fault, 1);
    chk("ato_cnt", {bus.dime_cnt, bus.nickel_cnt}, {4'd3, 4'd4});
    do_load(5, 6);
    chk("fault_load", {bus.dime_cnt, bus.nickel_cnt}, {4'd5, 4'd6});
    clr_fault();

    // Asynchronous reset in the middle of a payout.
    do_load(4, 4);
    bus.vend_req = 1'b1; bus.change_amt = 3'd4;
    step();
    bus.vend_req = 1'b0;
    bus.item_drop = 1'b1;
    step();
    bus.item_drop = 1'b0;
    step();
    chk("arst_pre_eject", bus.eject_dime, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_outs", {bus.motor, bus.eject_dime, bus.eject_nickel, bus.done, bus.busy, bus.fault}, 0);
    chk("arst_cnt", {bus.dime_cnt, bus.nickel_cnt}, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("arst_idle", bus.busy, 0);

    // Randomized vends against the greedy-change model.
    md = 0; mn = 0;
    for (int it = 0; it < 24; it++) begin
      chg = $urandom_range(0, 7);
      if (it == 0 || $urandom_range(0, 3) == 0) begin
        d = $urandom_range(0, 4); n = $urandom_range(0, 5);
        do_load(d, n);
        md = d; mn = n;
      end
      ld = ($urandom_range(0, 3) == 0);
      d = $urandom_range(0, 4); n = $urandom_range(0, 5);
      if (ld) begin md = d; mn = n; end
      ed = (chg / 2 < md) ? chg / 2 : md;
      r = chg - 2 * ed;
      en = (r < mn) ? r : mn;
      efault = (r > mn);
      do_vend(chg, $urandom_range(0, 10), ld, d, n, $urandom_range(0, 1), nd, nn, gd, gf);
      md -= ed; mn -= en;
      chk("rnd_dimes", nd, ed);
      chk("rnd_nickels", nn, en);
      chk("rnd_fault", gf, efault);
      chk("rnd_cnt", {bus.dime_cnt, bus.nickel_cnt}, {4'(md), 4'(mn)});
      chk("rnd_low", bus.low_change, (mn < 2) || (md == 0));
      if (gf) begin
        chk("rnd_fault_motor", bus.motor, 0);
        clr_fault();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
